tv_scanout_scheduler: RTL and testbench

- Sequences read-out of the line-buffer BRAM (one DATA_W-bit word per video line) against composite-video line/frame timing.
- Serialises each line's pixels into the PWM threshold that drives the RF antenna modulator.
- Sits between the BRAM read port and the 159 MHz PWM generator. Runs in the 27 MHz domain; the threshold is consumed as a quasi-static level.

---
 rtl/tv_scanout_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_tv_scanout_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tv_scanout_scheduler.sv
// Composite-video scan-out scheduler: reads one line-buffer word per active line and
// serialises it LSB first into PWM thresholds. Optional macro: TV_SCANOUT_TEST_PATTERN_EN.
module tv_scanout_scheduler #(
    parameter int H_TOTAL        = 1728,
    parameter int H_SYNC         = 127,
    parameter int H_ACTIVE_START = 320,
    parameter int PIX_DIV        = 4,
    parameter int PIXELS         = 300,
    parameter int V_TOTAL        = 625,
    parameter int V_SYNC_LINES   = 3,
    parameter int ACTIVE_FIRST   = 16,
    parameter int ACTIVE_LINES   = 608,
    parameter int ADDR_W         = 10,
    parameter int RD_LAT         = 1,
    parameter logic [7:0] THR_SYNC  = 8'd0,
    parameter logic [7:0] THR_BLACK = 8'd4,
    parameter logic [7:0] THR_WHITE = 8'd12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] bram_addr_rd,
    input  logic [PIXELS-1:0] bram_data_rd,
`ifdef TV_SCANOUT_TEST_PATTERN_EN
    input  logic              test_pattern,
`endif
    output logic [7:0]        pwm_threshold,
    output logic              line_start,
    output logic              frame_start,
    output logic              running
);

    localparam int H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int V_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int PS_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int PIX_END = H_ACTIVE_START + PIXELS * PIX_DIV;
    localparam int ACT_END = (ACTIVE_FIRST + ACTIVE_LINES < V_TOTAL) ?
                             (ACTIVE_FIRST + ACTIVE_LINES) : V_TOTAL;

    localparam logic [H_W-1:0]  H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]  H_CAP    = H_W'(RD_LAT + 1);
    localparam logic [H_W-1:0]  H_ZERO   = H_W'(0);
    localparam logic [V_W-1:0]  V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]  V_ZERO   = V_W'(0);
    localparam logic [V_W-1:0]  V_FIRST  = V_W'(ACTIVE_FIRST);
    localparam logic [H_W:0]    HX_SYNC  = (H_W + 1)'(H_SYNC);
    localparam logic [H_W:0]    HX_BROAD = (H_W + 1)'(H_TOTAL - H_SYNC);
    localparam logic [H_W:0]    HX_PIX0  = (H_W + 1)'(H_ACTIVE_START);
    localparam logic [H_W:0]    HX_PIXE  = (H_W + 1)'(PIX_END);
    localparam logic [V_W:0]    VX_SYNC  = (V_W + 1)'(V_SYNC_LINES);
    localparam logic [V_W:0]    VX_ACT0  = (V_W + 1)'(ACTIVE_FIRST);
    localparam logic [V_W:0]    VX_ACTE  = (V_W + 1)'(ACT_END);
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PIX_DIV - 1);
    localparam logic [PS_W-1:0] PS_ZERO  = PS_W'(0);

    // The capture slot must land before the first pixel and the pixel run must fit the line.
    generate
        if (RD_LAT < 1 || RD_LAT > 3 || RD_LAT + 1 >= H_ACTIVE_START) begin : g_bad_rd_lat
            $error("tv_scanout_scheduler: RD_LAT must be 1..3 with RD_LAT+1 < H_ACTIVE_START");
        end
        if (PIX_END > H_TOTAL) begin : g_bad_pix_end
            $error("tv_scanout_scheduler: pixel region exceeds H_TOTAL");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [H_W-1:0]     h_count_r;
    logic [V_W-1:0]     v_count_r;
    logic [H_W-1:0]     h_next_s;
    logic [V_W-1:0]     v_next_s;
    logic [PIXELS-1:0]  shift_r;
    logic [PS_W-1:0]    pix_sub_r;
    logic [7:0]         level_s;
    logic [H_W:0]       h_x_s;
    logic [V_W:0]       v_x_s;
    logic [V_W-1:0]     line_off_s;
    logic               run_s;
    logic               line_end_s;
    logic               frame_end_s;
    logic               active_s;
    logic               in_pix_s;
    logic               capture_s;
    logic               shift_s;
    logic               pix_bit_s;

    assign run_s       = (state_r != ST_IDLE);
    assign h_x_s       = {1'b0, h_count_r};
    assign v_x_s       = {1'b0, v_count_r};
    assign line_end_s  = (h_count_r == H_LAST);
    assign frame_end_s = line_end_s && (v_count_r == V_LAST);
    assign active_s    = (v_x_s >= VX_ACT0) && (v_x_s < VX_ACTE);
    assign in_pix_s    = (h_x_s >= HX_PIX0) && (h_x_s < HX_PIXE);
    assign line_off_s  = v_count_r - V_FIRST;
    assign capture_s   = run_s && active_s && (h_count_r == H_CAP);
    assign shift_s     = run_s && in_pix_s && (pix_sub_r == PS_LAST);

    // Next state and next counter values; a stop only takes effect at the frame wrap.
    always_comb begin
        state_s  = state_r;
        h_next_s = h_count_r;
        v_next_s = v_count_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) state_s = ST_RUN;
                else        state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!enable) state_s = frame_end_s ? ST_IDLE : ST_STOP;
                else         state_s = ST_RUN;
            end
            ST_STOP: begin
                if (enable)           state_s = ST_RUN;
                else if (frame_end_s) state_s = ST_IDLE;
                else                  state_s = ST_STOP;
            end
            default: state_s = ST_IDLE;
        endcase
        if (state_s == ST_IDLE || !run_s) begin
            h_next_s = H_ZERO;
            v_next_s = V_ZERO;
        end else if (line_end_s) begin
            h_next_s = H_ZERO;
            if (v_count_r == V_LAST) v_next_s = V_ZERO;
            else                     v_next_s = v_count_r + V_W'(1);
        end else begin
            h_next_s = h_count_r + H_W'(1);
            v_next_s = v_count_r;
        end
    end

    // Line level for the current counter position.
    always_comb begin
        level_s = THR_BLACK;
        if (v_x_s < VX_SYNC) begin
            if (h_x_s < HX_BROAD) level_s = THR_SYNC;
            else                  level_s = THR_BLACK;
        end else if (h_x_s < HX_SYNC) begin
            level_s = THR_SYNC;
        end else if (active_s && in_pix_s) begin
            if (pix_bit_s) level_s = THR_WHITE;
            else           level_s = THR_BLACK;
        end else begin
            level_s = THR_BLACK;
        end
    end

    // State, counters and the timing pulses, aligned with the counter values they mark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            h_count_r   <= H_ZERO;
            v_count_r   <= V_ZERO;
            running     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state_r     <= state_s;
            h_count_r   <= h_next_s;
            v_count_r   <= v_next_s;
            running     <= (state_s != ST_IDLE);
            line_start  <= (state_s != ST_IDLE) && (h_next_s == H_ZERO);
            frame_start <= (state_s != ST_IDLE) && (h_next_s == H_ZERO) && (v_next_s == V_ZERO);
        end
    end

    // Read address, pixel shift register and registered threshold; IDLE forces reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_addr_rd  <= ADDR_W'(0);
            shift_r       <= PIXELS'(0);
            pix_sub_r     <= PS_ZERO;
            pwm_threshold <= THR_SYNC;
        end else if (state_s == ST_IDLE) begin
            bram_addr_rd  <= ADDR_W'(0);
            shift_r       <= PIXELS'(0);
            pix_sub_r     <= PS_ZERO;
            pwm_threshold <= THR_SYNC;
        end else begin
            pwm_threshold <= run_s ? level_s : THR_SYNC;
            if (run_s && active_s && (h_count_r == H_ZERO)) begin
                bram_addr_rd <= ADDR_W'(line_off_s);
            end else begin
                bram_addr_rd <= bram_addr_rd;
            end
            if (capture_s)    shift_r <= bram_data_rd;
            else if (shift_s) shift_r <= shift_r >> 1'b1;
            else              shift_r <= shift_r;
            if (run_s && in_pix_s) begin
                pix_sub_r <= (pix_sub_r == PS_LAST) ? PS_ZERO : pix_sub_r + PS_W'(1);
            end else begin
                pix_sub_r <= PS_ZERO;
            end
        end
    end

`ifdef TV_SCANOUT_TEST_PATTERN_EN
    logic       tp_r;
    logic [3:0] pix_idx_r;

    // Test-pattern select latched at line start; 4-bit pixel index drives 8-pixel bars.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp_r      <= 1'b0;
            pix_idx_r <= 4'd0;
        end else if (state_s == ST_IDLE) begin
            tp_r      <= 1'b0;
            pix_idx_r <= 4'd0;
        end else begin
            if (run_s && (h_count_r == H_ZERO)) tp_r <= test_pattern;
            else                                tp_r <= tp_r;
            if (run_s && in_pix_s) begin
                if (shift_s) pix_idx_r <= pix_idx_r + 4'd1;
                else         pix_idx_r <= pix_idx_r;
            end else begin
                pix_idx_r <= 4'd0;
            end
        end
    end

    assign pix_bit_s = tp_r ? pix_idx_r[3] : shift_r[0];
`else
    assign pix_bit_s = shift_r[0];
`endif

endmodule

// File: tb/tb_tv_scanout_scheduler.sv
// Self-checking bench for tv_scanout_scheduler on a reduced timing set: table of spot
// vectors plus a cycle scoreboard fed by a spec-level reference model.
module tb_tv_scanout_scheduler;

    localparam int HT  = 64;
    localparam int HS  = 4;
    localparam int HAS = 8;
    localparam int PD  = 2;
    localparam int PX  = 8;
    localparam int VT  = 10;
    localparam int VS  = 1;
    localparam int AF  = 2;
    localparam int AL  = 6;
    localparam int AW  = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [AW-1:0] bram_addr_rd;
    logic [PX-1:0] bram_data_rd = 8'h00;
    logic [7:0]    pwm_threshold;
    logic          line_start;
    logic          frame_start;
    logic          running;
`ifdef TV_SCANOUT_TEST_PATTERN_EN
    logic          test_pattern = 1'b0;
`endif

    tv_scanout_scheduler #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_ACTIVE_START(HAS), .PIX_DIV(PD), .PIXELS(PX),
        .V_TOTAL(VT), .V_SYNC_LINES(VS), .ACTIVE_FIRST(AF), .ACTIVE_LINES(AL),
        .ADDR_W(AW), .RD_LAT(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .bram_addr_rd(bram_addr_rd),
        .bram_data_rd(bram_data_rd),
`ifdef TV_SCANOUT_TEST_PATTERN_EN
        .test_pattern(test_pattern),
`endif
        .pwm_threshold(pwm_threshold),
        .line_start(line_start),
        .frame_start(frame_start),
        .running(running)
    );

    always #5 clk = ~clk;

    // One-cycle-latency BRAM returning A5 xor address.
    always @(posedge clk) bram_data_rd <= 8'hA5 ^ bram_addr_rd[7:0];

    typedef struct {
        int         h;
        int         v;
        logic       run;
        logic       ls;
        logic       fs;
        logic [7:0] pwm;
        logic [9:0] addr;
    } exp_t;

    typedef struct {
        int         v;
        int         h;
        logic [7:0] pwm;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    int         errors = 0;
    int         checks = 0;
    int         cyc_n  = 0;
    int         last_fs = -1;
    int         last_ls = -1;
    int         m_state = 0;
    int         m_h = 0;
    int         m_v = 0;
    int         m_addr = 0;
    logic [7:0] m_level = 8'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc_n);
        end
    endtask

    function automatic logic [7:0] ref_level(input int h, input int v);
        logic [7:0] d;
        if (v < VS) return (h < HT - HS) ? 8'd0 : 8'd4;
        if (h < HS) return 8'd0;
        if (v >= AF && v < AF + AL && h >= HAS && h < HAS + PX * PD) begin
            d = 8'hA5 ^ 8'(v - AF);
            return d[(h - HAS) / PD] ? 8'd12 : 8'd4;
        end
        return 8'd4;
    endfunction

    task automatic model_reset();
        m_state = 0; m_h = 0; m_v = 0; m_addr = 0; m_level = 8'd0;
        last_fs = -1; last_ls = -1;
    endtask

    task automatic model_step();
        bit   fend;
        exp_t e;
        if (m_state == 0) begin
            if (enable) m_state = 1;
            m_h = 0; m_v = 0; m_level = 8'd0; m_addr = 0;
        end else begin
            m_level = ref_level(m_h, m_v);
            if (m_h == 0 && m_v >= AF && m_v < AF + AL) m_addr = m_v - AF;
            fend = (m_h == HT - 1) && (m_v == VT - 1);
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h++;
            end
            if (m_state == 1) begin
                if (!enable) m_state = fend ? 0 : 2;
            end else begin
                if (enable)    m_state = 1;
                else if (fend) m_state = 0;
            end
            if (m_state == 0) begin
                m_h = 0; m_v = 0; m_level = 8'd0; m_addr = 0;
            end
        end
        e.h = m_h; e.v = m_v; e.run = (m_state != 0);
        e.ls = e.run && (m_h == 0);
        e.fs = e.ls && (m_v == 0);
        e.pwm = m_level; e.addr = 10'(m_addr);
        sb_q.push_back(e);
    endtask

    // One clock: model predicts at the edge, DUT compared on the falling edge.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        model_step();
        cyc_n++;
        @(negedge clk);
        e = sb_q.pop_front();
        chk("pwm_threshold", 32'(pwm_threshold), 32'(e.pwm));
        chk("line_start",    32'(line_start),    32'(e.ls));
        chk("frame_start",   32'(frame_start),   32'(e.fs));
        chk("running",       32'(running),       32'(e.run));
        chk("bram_addr_rd",  32'(bram_addr_rd),  32'(e.addr));
        for (int i = 0; i < vecs.size(); i++) begin
            if (e.run && vecs[i].v == e.v && vecs[i].h == e.h)
                chk("vector_pwm", 32'(pwm_threshold), 32'(vecs[i].pwm));
        end
        if (!e.run) begin
            last_fs = -1; last_ls = -1;
        end
        if (frame_start === 1'b1) begin
            if (last_fs >= 0) chk("frame_period", 32'(cyc_n - last_fs), 32'(HT * VT));
            last_fs = cyc_n;
        end
        if (line_start === 1'b1) begin
            if (last_ls >= 0) chk("line_period", 32'(cyc_n - last_ls), 32'(HT));
            last_ls = cyc_n;
        end
    endtask

    task automatic run_until(input int v, input int h, input int limit, input string nm);
        int n = 0;
        while (!(m_state != 0 && m_v == v && m_h == h) && n < limit) begin
            cyc();
            n++;
        end
        chk(nm, 32'(m_state != 0 && m_v == v && m_h == h), 32'd1);
    endtask

    task automatic run_until_idle(input int limit);
        int n = 0;
        while (running !== 1'b0 && n < limit) begin
            cyc();
            n++;
        end
        chk("stop_to_idle", 32'(running), 32'd0);
    endtask

    initial begin
        // Spot vectors: {line, clock in line, threshold seen}; output lags counters by 1.
        vecs.push_back('{v:0, h:1,  pwm:8'd0});
        vecs.push_back('{v:0, h:60, pwm:8'd0});
        vecs.push_back('{v:0, h:61, pwm:8'd4});
        vecs.push_back('{v:0, h:63, pwm:8'd4});
        vecs.push_back('{v:1, h:0,  pwm:8'd4});
        vecs.push_back('{v:1, h:4,  pwm:8'd0});
        vecs.push_back('{v:1, h:5,  pwm:8'd4});
        vecs.push_back('{v:2, h:8,  pwm:8'd4});
        vecs.push_back('{v:2, h:9,  pwm:8'd12});
        vecs.push_back('{v:2, h:10, pwm:8'd12});
        vecs.push_back('{v:2, h:11, pwm:8'd4});
        vecs.push_back('{v:2, h:13, pwm:8'd12});
        vecs.push_back('{v:2, h:15, pwm:8'd4});
        vecs.push_back('{v:2, h:17, pwm:8'd4});
        vecs.push_back('{v:2, h:19, pwm:8'd12});
        vecs.push_back('{v:2, h:21, pwm:8'd4});
        vecs.push_back('{v:2, h:23, pwm:8'd12});
        vecs.push_back('{v:2, h:24, pwm:8'd12});
        vecs.push_back('{v:2, h:25, pwm:8'd4});
        vecs.push_back('{v:8, h:10, pwm:8'd4});
        vecs.push_back('{v:9, h:20, pwm:8'd4});

        rst_n  = 1'b0;
        enable = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_pwm",     32'(pwm_threshold), 32'd0);
        chk("reset_running", 32'(running),       32'd0);
        rst_n = 1'b1;

        repeat (100) cyc();

        enable = 1'b1;
        run_until(5, 10, 2000, "reach_v5_first");
        enable = 1'b0;
        run_until_idle(1000);
        repeat (20) cyc();

        enable = 1'b1;
        run_until(5, 0, 1000, "reach_v5_second");
        enable = 1'b0;
        run_until(7, 0, 500, "reach_v7_stopping");
        enable = 1'b1;
        run_until(1, 0, 1000, "reenable_wrap");
        chk("reenable_running", 32'(running), 32'd1);

        run_until(3, 20, 1000, "reach_reset_point");
        rst_n = 1'b0;
        #1;
        chk("midline_reset_pwm",     32'(pwm_threshold), 32'd0);
        chk("midline_reset_running", 32'(running),       32'd0);
        chk("midline_reset_addr",    32'(bram_addr_rd),  32'd0);
        chk("midline_reset_ls",      32'(line_start),    32'd0);
        model_reset();
        sb_q.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("frame_start_first_run", 32'(frame_start), 32'd1);
        repeat (200) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
